priority_encoder8to3_hs: RTL and testbench

- Registered 8-to-3 priority encoder. It is the inverse of the team's 3-to-8 decoder: one-hot or multi-hot request lines go in, a 3-bit code comes out.
- Request lines are captured into sticky pending bits.
- The highest-priority pending line is presented as a 3-bit code with a valid/ready handshake. The granted bit is cleared on acceptance.
- Sits between event/interrupt sources and a consumer that indexes them by code.

---
 rtl/priority_encoder8to3_hs.sv | 116 +++++++++++
 tb/tb_priority_encoder8to3_hs.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder8to3_hs.sv
// priority_encoder8to3_hs: registered 8-to-3 priority encoder with valid/ready handshake.
// Request lines accumulate into sticky pending bits. The winning line is presented as a
// 3-bit code and held until the consumer accepts it.
// Optional build macro PRIORITY_ENCODER_ROTATE_EN replaces fixed priority with a
// round-robin pointer. HIGH_FIRST then sets only the search direction.
module priority_encoder8to3_hs #(
  parameter int HIGH_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [7:0] A,
  output logic [2:0] Y,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_next;
  logic [7:0] pending_q;
  logic [7:0] pending_next;
  logic [7:0] clr;
  logic [2:0] y_q;
  logic [2:0] sel;
  logic       load;
  logic       accept;

`ifdef PRIORITY_ENCODER_ROTATE_EN
  logic [2:0] ptr_q;

  // Round-robin search starting at ptr, walking down (HIGH_FIRST) or up with wrap.
  // The loop runs from the far end inward, so the step nearest ptr overrides the rest.
  function automatic logic [2:0] select_line(input logic [7:0] v, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] s;
    s = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = (HIGH_FIRST != 0) ? (ptr - 3'(i)) : (ptr + 3'(i));
      if (v[idx]) s = idx;
    end
    return s;
  endfunction

  assign sel = select_line(pending_q, ptr_q);

  // Pointer moves one past the accepted line so that line becomes lowest priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_q <= 3'd0;
    else if (accept) ptr_q <= (HIGH_FIRST != 0) ? (y_q - 3'd1) : (y_q + 3'd1);
  end
`else
  // Fixed priority: the last set bit seen in the scan order wins.
  function automatic logic [2:0] select_line(input logic [7:0] v);
    logic [2:0] s;
    s = 3'd0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < 8; i++) if (v[i]) s = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--) if (v[i]) s = 3'(i);
    end
    return s;
  endfunction

  assign sel = select_line(pending_q);
`endif

  // Clear only the granted bit on acceptance. New requests are ORed in afterwards,
  // so a new request on that same line is kept (set wins over clear).
  assign clr          = accept ? (8'b1 << y_q) : 8'h00;
  assign pending_next = (pending_q & ~clr) | (E ? A : 8'h00);

  // Handshake FSM next-state logic: load a grant from IDLE, release it on acceptance.
  always_comb begin
    state_next = state_q;
    load       = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q != 8'h00) begin
          load       = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (ready) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pending and code registers. Y only changes when a new grant is loaded,
  // so no higher-priority request can preempt a grant in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      y_q       <= 3'd0;
    end else begin
      state_q   <= state_next;
      pending_q <= pending_next;
      if (load) y_q <= sel;
    end
  end

  assign Y       = y_q;
  assign valid   = (state_q == GRANT);
  assign pending = pending_q;
  assign busy    = (pending_q != 8'h00) | valid;

endmodule

// File: tb/tb_priority_encoder8to3_hs.sv
// Bench for priority_encoder8to3_hs: directed stimulus, a transaction-level reference
// model compared on every falling edge, and literal expectations on grant order.
module tb_priority_encoder8to3_hs;

  localparam int HF = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       E = 1'b0;
  logic [7:0] A = 8'h00;
  logic       ready = 1'b0;
  logic [2:0] Y;
  logic       valid;
  logic [7:0] pending;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
  int grants[$];

  priority_encoder8to3_hs #(.HIGH_FIRST(HF)) dut (
    .clk(clk), .rst_n(rst_n), .E(E), .A(A), .Y(Y), .valid(valid),
    .ready(ready), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a set of outstanding request lines, plus the one grant on offer.
  logic [7:0] m_pend;
  int         m_y;
  bit         m_valid;
  int         m_ptr;

  // The winner is found by rotating the request set so the preferred line sits at
  // one end, then taking the top set bit (via log2) or the lowest set bit (v & -v).
  function automatic int pick(input logic [7:0] v, input int ptr);
    logic [7:0] r;
    int base;
`ifdef PRIORITY_ENCODER_ROTATE_EN
    base = (HF != 0) ? ptr + 1 : ptr;
`else
    base = 0;
`endif
    for (int i = 0; i < 8; i++) r[i] = v[(i + base) % 8];
    if (HF != 0) return ($clog2(int'(r) + 1) - 1 + base) % 8;
    else         return ($clog2(int'(r & (~r + 8'd1))) + base) % 8;
  endfunction

  // Model state update: add new requests, remove the accepted line, then offer a new grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 8'h00; m_y <= 0; m_valid <= 1'b0; m_ptr <= 0;
    end else begin
      logic [7:0] served;
      served = (m_valid && ready) ? 8'(1 << m_y) : 8'h00;
      m_pend <= (m_pend & ~served) | (E ? A : 8'h00);
      if (!m_valid && m_pend != 8'h00) begin
        m_y <= pick(m_pend, m_ptr);
        m_valid <= 1'b1;
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
        m_ptr <= (HF != 0) ? (m_y + 7) % 8 : (m_y + 1) % 8;
      end
    end
  end

  // Compare the DUT against the model, and record each accepted code in grants[].
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_valid", int'(valid), int'(m_valid));
      chk("model_Y", int'(Y), m_y);
      chk("model_pending", int'(pending), int'(m_pend));
      chk("model_busy", int'(busy), int'((m_pend != 8'h00) || m_valid));
    end
    if (rst_n && valid && ready) grants.push_back(int'(Y));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int gq(input int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction

  initial begin
    // Reset with all requests present. Nothing is captured while reset is held.
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    E = 1'b1; A = 8'hFF; ready = 1'b0;
    tick(3);
    chk("rst_pending", int'(pending), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_Y", int'(Y), 0);
    rst_n = 1'b1;
    tick(1);
    A = 8'h00;
    chk("cap_pending", int'(pending), 8'hFF);
    chk("cap_valid", int'(valid), 0);
    tick(1);
    chk("first_valid", int'(valid), 1);
`ifndef PRIORITY_ENCODER_ROTATE_EN
    chk("first_Y", int'(Y), 7);
`else
    chk("first_Y", int'(Y), 0);
`endif
    // Drain all eight lines: eight grants, one every two cycles.
    grants.delete();
    ready = 1'b1;
    tick(16);
    chk("drain_pending", int'(pending), 0);
    chk("drain_count", grants.size(), 8);
`ifndef PRIORITY_ENCODER_ROTATE_EN
    for (int i = 0; i < 8; i++) chk($sformatf("drain_order%0d", i), gq(i), 7 - i);
`endif

    // Single-line sweep, with ready held high throughout.
    for (int k = 0; k < 8; k++) begin
      A = 8'(1 << k);
      tick(1);
      A = 8'h00;
      tick(1);
      chk($sformatf("sweep_Y%0d", k), int'(Y), k);
      chk($sformatf("sweep_v%0d", k), int'(valid), 1);
      tick(1);
      chk($sformatf("sweep_idle%0d", k), int'(valid), 0);
      chk($sformatf("sweep_pend%0d", k), int'(pending), 0);
    end

    // Several lines requested in one pulse: 8'b0010_1001.
    grants.delete();
    A = 8'b0010_1001;
    tick(1);
    A = 8'h00;
    tick(7);
    chk("multi_busy", int'(busy), 0);
    chk("multi_count", grants.size(), 3);
`ifndef PRIORITY_ENCODER_ROTATE_EN
    chk("multi_g0", gq(0), 5);
    chk("multi_g1", gq(1), 3);
    chk("multi_g2", gq(2), 0);
`endif

    // Backpressure: the grant stays fixed while a higher line arrives.
    ready = 1'b0;
    A = 8'h04;
    tick(1);
    A = 8'h00;
    tick(1);
    A = 8'h80;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      A = 8'h00;
      chk("bp_Y", int'(Y), 2);
      chk("bp_valid", int'(valid), 1);
    end
    chk("bp_pending", int'(pending), 8'h84);
    ready = 1'b1;
    tick(2);
    chk("bp_next_Y", int'(Y), 7);
    chk("bp_next_valid", int'(valid), 1);
    tick(1);
    chk("bp_done", int'(pending), 0);

    // A new request on the line being accepted in the same cycle is kept.
    ready = 1'b0;
    A = 8'h08;
    tick(2);
    A = 8'h00;
    chk("col_Y", int'(Y), 3);
    ready = 1'b1;
    A = 8'h08;
    tick(1);
    A = 8'h00;
    chk("col_pending", int'(pending), 8'h08);
    chk("col_idle", int'(valid), 0);
    tick(1);
    chk("col_regrant", int'(Y), 3);
    chk("col_regrant_v", int'(valid), 1);
    tick(1);
    chk("col_clear", int'(pending), 0);

    // With E low, new requests are dropped but lines already pending are still served.
    ready = 1'b0;
    A = 8'h10;
    tick(1);
    E = 1'b0;
    A = 8'hFF;
    tick(1);
    chk("egate_pending", int'(pending), 8'h10);
    tick(2);
    chk("egate_pending2", int'(pending), 8'h10);
    chk("egate_Y", int'(Y), 4);
    ready = 1'b1;
    tick(1);
    chk("egate_drop", int'(pending), 0);
    tick(2);
    chk("egate_quiet", int'(busy), 0);
    E = 1'b1;
    A = 8'h00;

    // Reset asserted during a grant clears valid at once, without waiting for a clock.
    ready = 1'b0;
    A = 8'h02;
    tick(1);
    A = 8'h00;
    tick(1);
    chk("ar_pre_valid", int'(valid), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(valid), 0);
    chk("ar_pending", int'(pending), 0);
    chk("ar_Y", int'(Y), 0);
    tick(1);
    rst_n = 1'b1;
    grants.delete();
    A = 8'h81;
    ready = 1'b1;
    tick(10);
    A = 8'h00;
    chk("alt_count_ge4", int'(grants.size() >= 4), 1);
`ifdef PRIORITY_ENCODER_ROTATE_EN
    chk("alt_g0", gq(0), 0);
    chk("alt_g1", gq(1), 7);
    chk("alt_g2", gq(2), 0);
    chk("alt_g3", gq(3), 7);
`else
    chk("alt_g0", gq(0), 7);
    chk("alt_g1", gq(1), 7);
    chk("alt_g2", gq(2), 7);
    chk("alt_g3", gq(3), 7);
`endif
    tick(6);
    chk("end_busy", int'(busy), 0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
